// File: rtl/msk_pkg.sv
// Shared definitions for the masked-sharing loader: FSM encoding and the
// counter width helper used to size word counters.
package msk_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } state_e;

   // Bits needed to represent the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/msk_word_cnt.sv
// Word counter for the sharing loader: synchronous clear, increment per
// accepted word, and a flag marking the final word position of a sharing.
module msk_word_cnt #(
   parameter int NW = 8,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          last_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   // Clear wins over increment so an abort never leaves a stale count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = '0;
      else if (inc_i) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == CW'(NW - 1));

endmodule

// File: rtl/msk_shares_loader.sv
// Collects NW words from the SW interface into one d*Nbits sharing register
// and presents it downstream with a valid/ready handshake.
module msk_shares_loader
   import msk_pkg::*;
#(
   parameter  int Nbits = 128,
   parameter  int d     = 2,
   parameter  int W     = 32,
   localparam int NW    = d * Nbits / W,
   localparam int CW    = cnt_width(NW)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic [W-1:0]         in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [d*Nbits-1:0]   state_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        word_cnt,
   output state_e               fsm_state
);

   // Handshake rule on both ports: a word/sharing transfers on the rising
   // edge where valid and ready are both 1; clear cancels either transfer.
   if ((d * Nbits) % W != 0) begin : g_bad_width
      $fatal(1, "msk_shares_loader: d*Nbits must be a multiple of W");
   end

   state_e              state_q, state_d;
   logic [d*Nbits-1:0]  buf_q;
   logic [NW-1:0]       word_en;
   logic                in_acc, out_acc, last_word;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q == FULL);
   assign in_acc    = in_valid & in_ready & ~clear;
   assign out_acc   = out_valid & out_ready & ~clear;

   msk_word_cnt #(.NW(NW), .CW(CW)) u_word_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clear | out_acc),
      .inc_i  (in_acc),
      .cnt_o  (word_cnt),
      .last_o (last_word)
   );

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (in_acc) state_d = last_word ? FULL : FILL;
            FILL:  if (in_acc && last_word) state_d = FULL;
            FULL:  if (out_acc) state_d = EMPTY;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // The counter value doubles as the write pointer into the buffer.
   always_comb begin
      word_en = '0;
      for (int k = 0; k < NW; k++) begin
         if (in_acc && (word_cnt == CW'(k))) word_en[k] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else begin
         for (int k = 0; k < NW; k++) begin
            if (word_en[k]) buf_q[k*W +: W] <= in_data;
         end
      end
   end

   assign state_out = buf_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_msk_shares_loader.sv
// Bench for msk_shares_loader with the default 2x128-bit sharing, 32-bit words.
module tb_msk_shares_loader;
  import msk_pkg::*;

  localparam int W  = 32;
  localparam int NW = 8;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] state_out;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   word_cnt;
  state_e       fsm_state;

  logic [255:0] exp_q[$];
  int n_tests;
  int n_fail;

  msk_shares_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_out (state_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: inputs change and outputs are sampled at the falling edge.
  task automatic drive_load(input logic [31:0] base);
    logic [255:0] exp;
    exp = '0;
    for (int k = 0; k < NW; k++) begin
      exp[k*W +: W] = base + 32'(k);
      in_valid = 1'b1;
      in_data  = base + 32'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    exp_q.push_back(exp);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    n_tests++;
    if (out_valid !== 1'b0 || state_out !== 256'd0 || word_cnt !== 4'd0 ||
        in_ready !== 1'b1 || fsm_state !== EMPTY) begin
      n_fail++;
      $display("FAIL reset: out_valid=%b in_ready=%b word_cnt=%0d state=%0d state_out=%h, want 0 1 0 0 0",
               out_valid, in_ready, word_cnt, fsm_state, state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp;
    exp = '0;
    for (int k = 0; k < NW; k++) begin
      exp[k*W +: W] = 32'(k);
      in_valid = 1'b1;
      in_data  = 32'(k);
      @(negedge clk);
      n_tests++;
      if (word_cnt !== 4'(k + 1) || out_valid !== (k == NW - 1)) begin
        n_fail++;
        $display("FAIL b2b_step%0d: word_cnt=%0d out_valid=%b, want %0d %b",
                 k, word_cnt, out_valid, k + 1, (k == NW - 1));
      end
    end
    in_valid = 1'b0;
    exp_q.push_back(exp);
    n_tests++;
    if (in_ready !== 1'b0 || fsm_state !== FULL) begin
      n_fail++;
      $display("FAIL b2b_full: in_ready=%b state=%0d, want 0 %0d", in_ready, fsm_state, FULL);
    end
    exp = exp_q.pop_front();
    n_tests++;
    if (state_out !== exp || state_out[31:0] !== 32'h0 || state_out[255:224] !== 32'h7) begin
      n_fail++;
      $display("FAIL b2b_data: got %h want %h", state_out, exp);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [255:0] exp;
    drive_load(32'h0000_0100);
    exp = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || state_out !== exp || in_ready !== 1'b0 || word_cnt !== 4'd8) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: out_valid=%b in_ready=%b word_cnt=%0d state_out=%h want 1 0 8 %h",
                 c, out_valid, in_ready, word_cnt, state_out, exp);
      end
    end
    in_valid = 1'b0;
    consume();
    n_tests++;
    if (out_valid !== 1'b0 || word_cnt !== 4'd0 || in_ready !== 1'b1 || fsm_state !== EMPTY) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b word_cnt=%0d in_ready=%b state=%0d want 0 0 1 0",
               out_valid, word_cnt, in_ready, fsm_state);
    end
  endtask

  task automatic test_gapped();
    logic [255:0] exp;
    exp = '0;
    for (int k = 0; k < NW; k++) begin
      exp[k*W +: W] = 32'(k);
      in_valid = 1'b0;
      in_data  = $urandom;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      n_tests++;
      if (word_cnt !== 4'(k)) begin
        n_fail++;
        $display("FAIL gapped_idle%0d: word_cnt=%0d want %0d", k, word_cnt, k);
      end
      in_valid = 1'b1;
      in_data  = 32'(k);
      @(negedge clk);
      n_tests++;
      if (word_cnt !== 4'(k + 1)) begin
        n_fail++;
        $display("FAIL gapped_acc%0d: word_cnt=%0d want %0d", k, word_cnt, k + 1);
      end
    end
    in_valid = 1'b0;
    exp_q.push_back(exp);
    exp = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || state_out !== exp) begin
      n_fail++;
      $display("FAIL gapped_data: out_valid=%b state_out=%h want 1 %h", out_valid, state_out, exp);
    end
    consume();
  endtask

  task automatic test_clear();
    logic [255:0] exp;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h55 + 32'(k);
      @(negedge clk);
    end
    clear    = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if (word_cnt !== 4'd0 || fsm_state !== EMPTY || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_abort: word_cnt=%0d state=%0d out_valid=%b in_ready=%b want 0 0 0 1",
               word_cnt, fsm_state, out_valid, in_ready);
    end
    drive_load(32'h0000_00A0);
    exp = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || state_out !== exp || state_out[31:0] !== 32'hA0 ||
        state_out[255:224] !== 32'hA7) begin
      n_fail++;
      $display("FAIL clear_reload: out_valid=%b state_out=%h want 1 %h", out_valid, state_out, exp);
    end
    consume();
  endtask

  task automatic test_async_reset();
    logic [255:0] exp;
    drive_load(32'h0000_0200);
    exp = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || state_out !== exp) begin
      n_fail++;
      $display("FAIL areset_pre: out_valid=%b state_out=%h want 1 %h", out_valid, state_out, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || state_out !== 256'd0 || in_ready !== 1'b1 || word_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL areset_full: out_valid=%b in_ready=%b word_cnt=%0d state_out=%h want 0 1 0 0",
               out_valid, in_ready, word_cnt, state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // partial fill then reset: the buffered words must be discarded
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h300 + 32'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (word_cnt !== 4'd0 || fsm_state !== EMPTY || state_out !== 256'd0) begin
      n_fail++;
      $display("FAIL areset_partial: word_cnt=%0d state=%0d state_out=%h want 0 0 0",
               word_cnt, fsm_state, state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h400 + 32'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || word_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL areset_fresh: out_valid=%b word_cnt=%0d want 0 3", out_valid, word_cnt);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_clear_and_out();
    logic [255:0] exp;
    drive_load(32'h0000_0500);
    exp = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || state_out !== exp) begin
      n_fail++;
      $display("FAIL clr_out_pre: out_valid=%b state_out=%h want 1 %h", out_valid, state_out, exp);
    end
    clear     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hCAFE_F00D;
    @(negedge clk);
    clear     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_tests++;
    if (fsm_state !== EMPTY || word_cnt !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_out: state=%0d word_cnt=%0d out_valid=%b in_ready=%b want 0 0 0 1",
               fsm_state, word_cnt, out_valid, in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (word_cnt !== 4'd0 || fsm_state !== EMPTY) begin
      n_fail++;
      $display("FAIL clr_out_settle: word_cnt=%0d state=%0d want 0 0", word_cnt, fsm_state);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gapped();
    test_clear();
    test_async_reset();
    test_clear_and_out();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d sharings left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
